reset_sequencer: RTL

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged reset release controller.
// After the reset source drops, all stages stay asserted for HOLD_CYCLES,
// then rst_out bits are released one at a time (bit 0 first), STAGE_GAP
// cycles apart. seq_done is high once every stage is released.
// A software request restarts the whole sequence; rst_cause records why
// the last sequence started (0 = system, 1 = software, 2 = watchdog).
// Optional watchdog: define RESET_SEQ_WATCHDOG_EN to compile in a 16-bit
// watchdog that restarts the sequence when RUN is not serviced by wdt_kick.
module reset_sequencer #(
   parameter int HOLD_CYCLES = 4,
   parameter int STAGES      = 3,
   parameter int STAGE_GAP   = 8,
   parameter int WDT_TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sw_rst_req,
   input  logic              wdt_kick,
   output logic [STAGES-1:0] rst_out,
   output logic              seq_done,
   output logic [1:0]        rst_cause
);

   typedef enum logic [1:0] {
      ASSERT  = 2'd0,
      HOLD    = 2'd1,
      RELEASE = 2'd2,
      RUN     = 2'd3
   } state_t;

   localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYCLES - 1);
   localparam logic [7:0] GAP_LAST   = 8'(STAGE_GAP - 1);
   localparam logic [3:0] STAGE_LAST = 4'(STAGES - 1);

   localparam logic [1:0] CAUSE_SYS = 2'd0;
   localparam logic [1:0] CAUSE_SW  = 2'd1;
   localparam logic [1:0] CAUSE_WDT = 2'd2;

   state_t            state_reg, state_next;
   logic [7:0]        hold_cnt_reg, hold_cnt_next;
   logic [7:0]        gap_cnt_reg, gap_cnt_next;
   logic [3:0]        stage_idx_reg, stage_idx_next;
   logic [STAGES-1:0] rst_out_reg, rst_out_next;
   logic              seq_done_reg, seq_done_next;
   logic [1:0]        cause_reg, cause_next;

   // Per-stage control decided by the FSM: force all stages on, or clear one.
   logic              set_all;
   logic              clr_en;
   logic [3:0]        clr_idx;

   // High in the RUN cycle where the watchdog expires without a kick.
   logic              wdt_fire;

`ifdef RESET_SEQ_WATCHDOG_EN
   localparam logic [15:0] WDT_LAST = 16'(WDT_TIMEOUT - 1);

   logic [15:0] wdt_cnt_reg, wdt_cnt_next;

   assign wdt_fire = (state_reg == RUN) && !wdt_kick && (wdt_cnt_reg == WDT_LAST);

   // Watchdog counts only while staying in RUN; kick or RUN entry clears it.
   always_comb begin
      wdt_cnt_next = 16'd0;
      if ((state_reg == RUN) && (state_next == RUN) && !wdt_kick) begin
         if (wdt_cnt_reg == WDT_LAST) begin
            wdt_cnt_next = wdt_cnt_reg;
         end else begin
            wdt_cnt_next = wdt_cnt_reg + 16'd1;
         end
      end
   end

   // Watchdog counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         wdt_cnt_reg <= 16'd0;
      end else begin
         wdt_cnt_reg <= wdt_cnt_next;
      end
   end
`else
   // No watchdog: the kick input and timeout parameter have no effect.
   localparam logic [15:0] unused_wdt_timeout = 16'(WDT_TIMEOUT);
   logic unused_wdt_kick;

   assign unused_wdt_kick = wdt_kick;
   assign wdt_fire        = 1'b0;
`endif

   // Next-state logic: sequencing, counters and reset-cause tracking.
   always_comb begin
      state_next     = state_reg;
      hold_cnt_next  = hold_cnt_reg;
      gap_cnt_next   = gap_cnt_reg;
      stage_idx_next = stage_idx_reg;
      cause_next     = cause_reg;
      set_all        = 1'b0;
      clr_en         = 1'b0;
      clr_idx        = stage_idx_reg;

      case (state_reg)
         ASSERT: begin
            // Only reached here with reset low (reset itself is handled in
            // the register block), so always start holding next cycle.
            set_all        = 1'b1;
            state_next     = HOLD;
            hold_cnt_next  = 8'd0;
            gap_cnt_next   = 8'd0;
            stage_idx_next = 4'd0;
            if (sw_rst_req) begin
               cause_next = CAUSE_SW;
            end
         end

         HOLD: begin
            if (sw_rst_req) begin
               state_next     = ASSERT;
               set_all        = 1'b1;
               hold_cnt_next  = 8'd0;
               gap_cnt_next   = 8'd0;
               stage_idx_next = 4'd0;
               cause_next     = CAUSE_SW;
            end else if (hold_cnt_reg == HOLD_LAST) begin
               // Stage 0 releases on the same edge that leaves HOLD.
               clr_en  = 1'b1;
               clr_idx = 4'd0;
               if (STAGES == 1) begin
                  state_next = RUN;
               end else begin
                  state_next     = RELEASE;
                  gap_cnt_next   = 8'd0;
                  stage_idx_next = 4'd1;
               end
            end else begin
               hold_cnt_next = hold_cnt_reg + 8'd1;
            end
         end

         RELEASE: begin
            if (sw_rst_req) begin
               state_next     = ASSERT;
               set_all        = 1'b1;
               hold_cnt_next  = 8'd0;
               gap_cnt_next   = 8'd0;
               stage_idx_next = 4'd0;
               cause_next     = CAUSE_SW;
            end else if (gap_cnt_reg == GAP_LAST) begin
               clr_en  = 1'b1;
               clr_idx = stage_idx_reg;
               if (stage_idx_reg >= STAGE_LAST) begin
                  // Last stage released: counters stay saturated.
                  state_next = RUN;
               end else begin
                  stage_idx_next = stage_idx_reg + 4'd1;
                  gap_cnt_next   = 8'd0;
               end
            end else begin
               gap_cnt_next = gap_cnt_reg + 8'd1;
            end
         end

         RUN: begin
            if (sw_rst_req) begin
               state_next     = ASSERT;
               set_all        = 1'b1;
               hold_cnt_next  = 8'd0;
               gap_cnt_next   = 8'd0;
               stage_idx_next = 4'd0;
               cause_next     = CAUSE_SW;
            end else if (wdt_fire) begin
               state_next     = ASSERT;
               set_all        = 1'b1;
               hold_cnt_next  = 8'd0;
               gap_cnt_next   = 8'd0;
               stage_idx_next = 4'd0;
               cause_next     = CAUSE_WDT;
            end
         end

         default: begin
            state_next = ASSERT;
            set_all    = 1'b1;
         end
      endcase

      // seq_done is high only while the FSM stays in RUN, so it rises one
      // cycle after the final stage clears and drops as RUN is left.
      seq_done_next = (state_reg == RUN) && (state_next == RUN);
   end

   // Per-stage reset bits: forced on as a group, cleared one at a time.
   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
         always_comb begin
            rst_out_next[gi] = rst_out_reg[gi];
            if (set_all) begin
               rst_out_next[gi] = 1'b1;
            end else if (clr_en && (clr_idx == 4'(gi))) begin
               rst_out_next[gi] = 1'b0;
            end
         end
      end
   endgenerate

   // State, counter and output registers; system reset wins over all requests.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ASSERT;
         hold_cnt_reg  <= 8'd0;
         gap_cnt_reg   <= 8'd0;
         stage_idx_reg <= 4'd0;
         rst_out_reg   <= '1;
         seq_done_reg  <= 1'b0;
         cause_reg     <= CAUSE_SYS;
      end else begin
         state_reg     <= state_next;
         hold_cnt_reg  <= hold_cnt_next;
         gap_cnt_reg   <= gap_cnt_next;
         stage_idx_reg <= stage_idx_next;
         rst_out_reg   <= rst_out_next;
         seq_done_reg  <= seq_done_next;
         cause_reg     <= cause_next;
      end
   end

   assign rst_out   = rst_out_reg;
   assign seq_done  = seq_done_reg;
   assign rst_cause = cause_reg;

endmodule
